// File: rtl/qtu_pkg.sv
// -----------------------------------------------------------------------------
// qtu_pkg
// Shared definitions for the EER-RL neighbour/Q-table updater:
//   - default field width (ID / hops / energy / Q, unsigned Q2.14 for Q and E)
//   - packet-type codes as decoded upstream
//   - FSM state encodings for the top-level updater and the CH-list helper
//   - Q2.14 reference constants
// -----------------------------------------------------------------------------
package qtu_pkg;

  localparam int QTU_WORD_WIDTH = 16;

  // Packet types; only PKT_INVALID is rejected by the updater.
  localparam logic [2:0] PKT_INVALID = 3'b000;
  localparam logic [2:0] PKT_HELLO   = 3'b001;
  localparam logic [2:0] PKT_CH_ADV  = 3'b010;
  localparam logic [2:0] PKT_JOIN    = 3'b011;
  localparam logic [2:0] PKT_ACK     = 3'b100;
  localparam logic [2:0] PKT_DATA    = 3'b101;

  // Q2.14 reference points.
  localparam logic [15:0] Q_ZERO = 16'h0000;
  localparam logic [15:0] Q_HALF = 16'h2000;
  localparam logic [15:0] Q_ONE  = 16'h4000;
  localparam logic [15:0] Q_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    NSRCH,
    NWR,
    RESCAN,
    CSRCH,
    CWR,
    DONE
  } qtu_state_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_SRCH,
    CH_WR
  } ch_state_e;

endpackage

// File: rtl/qtable_update_param_if.sv
// -----------------------------------------------------------------------------
// qtable_update_param_if
// Bundles the packet-field inputs, table read port and status outputs of the
// Q-table updater.
//   master : packet decoder / routing side (drives en, f*, rd_idx)
//   slave  : the updater (drives rd_*, counts, best_*, busy/done/drop, fulls)
// -----------------------------------------------------------------------------
interface qtable_update_param_if
  import qtu_pkg::*;
#(
  parameter int WORD_WIDTH = QTU_WORD_WIDTH,
  parameter int IDX_W      = 5,
  parameter int CIDX_W     = 4
);

  logic                  en;
  logic [WORD_WIDTH-1:0] myNodeID;
  logic [WORD_WIDTH-1:0] fSourceID;
  logic [WORD_WIDTH-1:0] fSourceHops;
  logic [WORD_WIDTH-1:0] fClusterID;
  logic [WORD_WIDTH-1:0] fEnergyLeft;
  logic [WORD_WIDTH-1:0] fQValue;
  logic [WORD_WIDTH-1:0] fKnownCH;
  logic [2:0]            fPacketType;
  logic [IDX_W-1:0]      rd_idx;

  logic [WORD_WIDTH-1:0] rd_id;
  logic [WORD_WIDTH-1:0] rd_hops;
  logic [WORD_WIDTH-1:0] rd_cid;
  logic [WORD_WIDTH-1:0] rd_energy;
  logic [WORD_WIDTH-1:0] rd_q;
  logic [IDX_W-1:0]      neighborCount;
  logic [CIDX_W-1:0]     knownCHCount;
  logic [IDX_W-1:0]      best_idx;
  logic [WORD_WIDTH-1:0] best_q;
  logic                  best_valid;
  logic                  busy;
  logic                  done;
  logic                  drop;
  logic                  table_full;
  logic                  ch_full;

  modport master (
    output en, myNodeID, fSourceID, fSourceHops, fClusterID, fEnergyLeft,
           fQValue, fKnownCH, fPacketType, rd_idx,
    input  rd_id, rd_hops, rd_cid, rd_energy, rd_q, neighborCount,
           knownCHCount, best_idx, best_q, best_valid, busy, done, drop,
           table_full, ch_full
  );

  modport slave (
    input  en, myNodeID, fSourceID, fSourceHops, fClusterID, fEnergyLeft,
           fQValue, fKnownCH, fPacketType, rd_idx,
    output rd_id, rd_hops, rd_cid, rd_energy, rd_q, neighborCount,
           knownCHCount, best_idx, best_q, best_valid, busy, done, drop,
           table_full, ch_full
  );

endinterface

// File: rtl/qtu_ch_list.sv
// -----------------------------------------------------------------------------
// qtu_ch_list
// De-duplicating list of known cluster heads.
// A start_i pulse captures key_i; the list is then scanned one entry per cycle
// (one cycle if empty). srch_last_o marks the final search cycle, after which
// one write cycle (done_o=1) appends the key if it was absent and the list is
// not full. A miss on a full list is discarded silently.
//   clk, nrst   clock, synchronous active-high reset
//   start_i     begin a lookup/append of key_i
//   key_i       CH ID to record
//   srch_last_o last search cycle (comb)
//   done_o      write cycle (comb)
//   count_o     valid entries; full_o count_o == MAX_CH
// -----------------------------------------------------------------------------
module qtu_ch_list
  import qtu_pkg::*;
#(
  parameter int WORD_WIDTH = QTU_WORD_WIDTH,
  parameter int MAX_CH     = 8,
  parameter int CIDX_W     = $clog2(MAX_CH + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] key_i,
  output logic                  srch_last_o,
  output logic                  done_o,
  output logic [CIDX_W-1:0]     count_o,
  output logic                  full_o
);

  localparam int CAW = $clog2(MAX_CH);

  ch_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0] list_q [MAX_CH];
  logic [WORD_WIDTH-1:0] key_q;
  logic [CIDX_W-1:0]     count_q;
  logic [CIDX_W-1:0]     scan_q;
  logic                  hit_q;
  logic                  cur_hit;

  assign full_o  = (count_q == CIDX_W'(MAX_CH));
  assign count_o = count_q;
  assign cur_hit = (count_q != '0) && (list_q[scan_q[CAW-1:0]] == key_q);

  assign srch_last_o = (state_q == CH_SRCH) &&
                       (count_q == '0 || cur_hit || scan_q == count_q - CIDX_W'(1));
  assign done_o      = (state_q == CH_WR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CH_IDLE: if (start_i)     state_d = CH_SRCH;
      CH_SRCH: if (srch_last_o) state_d = CH_WR;
      CH_WR:                    state_d = CH_IDLE;
      default:                  state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= CH_IDLE;
      key_q   <= '0;
      count_q <= '0;
      scan_q  <= '0;
      hit_q   <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) list_q[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        CH_IDLE: begin
          if (start_i) begin
            key_q  <= key_i;
            scan_q <= '0;
            hit_q  <= 1'b0;
          end
        end
        CH_SRCH: begin
          if (srch_last_o) hit_q  <= cur_hit;
          else             scan_q <= scan_q + CIDX_W'(1);
        end
        CH_WR: begin
          if (!hit_q && !full_o) begin
            list_q[count_q[CAW-1:0]] <= key_q;
            count_q                  <= count_q + CIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/qtable_update_param.sv
// -----------------------------------------------------------------------------
// qtable_update_param
// Neighbour / Q-table updater for an EER-RL node. Per accepted packet it
// searches the neighbour table by source ID, overwrites a hit or appends a new
// entry, keeps the max-Q entry (best_*) current, and records the advertised
// cluster head in a de-duplicated CH list.
//   clk          clock
//   nrst         synchronous reset, active HIGH
//   bus (slave)  en + packet fields in; async table read (rd_idx -> rd_*);
//                counts, best_*, busy/done/drop pulses, full flags out
// Sequence: IDLE -> NSRCH -> NWR -> [RESCAN] -> [CSRCH -> CWR] -> DONE.
// Rejected packets go IDLE -> DONE with no writes.
// -----------------------------------------------------------------------------
module qtable_update_param
  import qtu_pkg::*;
#(
  parameter int WORD_WIDTH    = QTU_WORD_WIDTH,
  parameter int MAX_NEIGHBORS = 16,
  parameter int MAX_CH        = 8,
  parameter int IDX_W         = $clog2(MAX_NEIGHBORS + 1),
  parameter int CIDX_W        = $clog2(MAX_CH + 1)
) (
  input logic                  clk,
  input logic                  nrst,
  qtable_update_param_if.slave bus
);

  localparam int AW = $clog2(MAX_NEIGHBORS);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] cid;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] q;
  } entry_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] cid;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] q;
    logic [WORD_WIDTH-1:0] kch;
  } pkt_t;

  qtu_state_e            state_q, state_d;
  entry_t                tbl_q [MAX_NEIGHBORS];
  pkt_t                  pkt_q;
  logic [IDX_W-1:0]      count_q;
  logic [IDX_W-1:0]      scan_q;
  logic                  hit_q;
  logic [IDX_W-1:0]      hit_idx_q;
  logic                  drop_q;      // drop decided in NWR, shown with done
  logic                  busy_q;
  logic                  done_q;
  logic                  drop_o_q;
  logic [IDX_W-1:0]      best_idx_q;
  logic [WORD_WIDTH-1:0] best_q_q;
  logic                  best_valid_q;

  logic                  reject;
  logic                  tbl_full;
  logic                  srch_hit;
  logic                  srch_last;
  logic                  rescan_last;
  logic                  need_rescan;
  logic [IDX_W-1:0]      wr_idx;
  logic                  ch_start;
  logic                  ch_srch_last;
  logic                  ch_done;
  logic [CIDX_W-1:0]     ch_count;
  logic                  ch_full;
  entry_t                rd_entry;
  entry_t                scan_entry;

  assign reject   = (bus.fPacketType == PKT_INVALID) || (bus.fSourceID == bus.myNodeID);
  assign tbl_full = (count_q == IDX_W'(MAX_NEIGHBORS));

  assign scan_entry  = tbl_q[scan_q[AW-1:0]];
  assign srch_hit    = (count_q != '0) && (scan_entry.id == pkt_q.src);
  assign srch_last   = (count_q == '0) || srch_hit || (scan_q == count_q - IDX_W'(1));
  assign rescan_last = (scan_q == count_q - IDX_W'(1));

  // Only lowering the current best entry can hide a better one elsewhere.
  assign need_rescan = hit_q && best_valid_q && (hit_idx_q == best_idx_q) &&
                       (pkt_q.q < best_q_q);
  assign wr_idx      = hit_q ? hit_idx_q : count_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ch_start = 1'b0;
    unique case (state_q)
      IDLE:   if (bus.en) state_d = reject ? DONE : NSRCH;
      NSRCH:  if (srch_last) state_d = NWR;
      NWR: begin
        if (need_rescan) begin
          state_d = RESCAN;
        end else if (pkt_q.kch != '0) begin
          state_d  = CSRCH;
          ch_start = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      RESCAN: begin
        if (rescan_last) begin
          if (pkt_q.kch != '0) begin
            state_d  = CSRCH;
            ch_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      CSRCH:  if (ch_srch_last) state_d = CWR;
      CWR:    state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= IDLE;
      pkt_q        <= '0;
      count_q      <= '0;
      scan_q       <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_o_q     <= 1'b0;
      best_idx_q   <= '0;
      best_q_q     <= '0;
      best_valid_q <= 1'b0;
      // NOTE: the table is register-based and must read back as zero after
      // reset, so it is cleared here rather than left uninitialised like a RAM.
      for (int i = 0; i < MAX_NEIGHBORS; i++) tbl_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= 1'b0;
      drop_o_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.en) begin
            pkt_q     <= '{src: bus.fSourceID, hops: bus.fSourceHops,
                           cid: bus.fClusterID, energy: bus.fEnergyLeft,
                           q: bus.fQValue, kch: bus.fKnownCH};
            busy_q    <= 1'b1;
            scan_q    <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            drop_q    <= 1'b0;
          end
        end
        NSRCH: begin
          if (srch_hit) begin
            hit_q     <= 1'b1;
            hit_idx_q <= scan_q;
          end else if (!srch_last) begin
            scan_q <= scan_q + IDX_W'(1);
          end
        end
        NWR: begin
          scan_q <= '0;
          if (hit_q || !tbl_full) begin
            tbl_q[wr_idx[AW-1:0]] <= '{id: pkt_q.src, hops: pkt_q.hops,
                                       cid: pkt_q.cid, energy: pkt_q.energy,
                                       q: pkt_q.q};
            if (!hit_q) count_q <= count_q + IDX_W'(1);
            if (!best_valid_q || pkt_q.q > best_q_q) begin
              best_idx_q   <= wr_idx;
              best_q_q     <= pkt_q.q;
              best_valid_q <= 1'b1;
            end else if (hit_q && hit_idx_q == best_idx_q) begin
              // Equal or lower Q on the best entry; a lower value is then
              // corrected by RESCAN.
              best_q_q <= pkt_q.q;
            end
          end else begin
            drop_q <= 1'b1;
          end
        end
        RESCAN: begin
          // Entry 0 seeds the search; strict > keeps the lowest index on ties.
          if (scan_q == '0 || scan_entry.q > best_q_q) begin
            best_idx_q <= scan_q;
            best_q_q   <= scan_entry.q;
          end
          scan_q <= scan_q + IDX_W'(1);
        end
        DONE: begin
          done_q   <= 1'b1;
          drop_o_q <= drop_q;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  qtu_ch_list #(
    .WORD_WIDTH (WORD_WIDTH),
    .MAX_CH     (MAX_CH),
    .CIDX_W     (CIDX_W)
  ) u_ch_list (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (ch_start),
    .key_i       (pkt_q.kch),
    .srch_last_o (ch_srch_last),
    .done_o      (ch_done),
    .count_o     (ch_count),
    .full_o      (ch_full)
  );

  // Asynchronous read port; entries at or beyond the count read as zero.
  always_comb begin
    rd_entry = '0;
    if (bus.rd_idx < count_q) rd_entry = tbl_q[bus.rd_idx[AW-1:0]];
  end

  assign bus.rd_id         = rd_entry.id;
  assign bus.rd_hops       = rd_entry.hops;
  assign bus.rd_cid        = rd_entry.cid;
  assign bus.rd_energy     = rd_entry.energy;
  assign bus.rd_q          = rd_entry.q;
  assign bus.neighborCount = count_q;
  assign bus.knownCHCount  = ch_count;
  assign bus.best_idx      = best_idx_q;
  assign bus.best_q        = best_q_q;
  assign bus.best_valid    = best_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.drop          = drop_o_q;
  assign bus.table_full    = tbl_full;
  assign bus.ch_full       = ch_full;

  // The CH helper's write cycle is tracked by the CWR state itself.
  logic unused_ch_done;
  assign unused_ch_done = ch_done;

endmodule
